// File: rtl/crc_stream_pkg.sv
// rtl/crc_stream_pkg.sv - state type and bitwise CRC helpers shared by crc_stream_engine
package crc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] width_mask(input int width);
        logic [32:0] m;
        m = (33'd1 << width) - 33'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] reflect_poly(input logic [31:0] poly, input int width);
        logic [31:0] r;
        logic [4:0]  j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                j    = 5'(width - 1 - i);
                r[i] = poly[j];
            end
        end
        return r;
    endfunction

    // Reflected mode expects poly already bit-reversed; bits above width are masked on return.
    function automatic logic [31:0] crc_byte_step(input logic [31:0] crc, input logic [7:0] data,
                                                  input logic [31:0] poly, input logic reflect,
                                                  input int width);
        logic [31:0] c;
        logic [4:0]  top;
        top = 5'(width - 1);
        if (reflect) begin
            c = crc ^ {24'd0, data};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        end else begin
            c = crc ^ ({24'd0, data} << (width - 8));
            for (int b = 0; b < 8; b++) c = c[top] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c & width_mask(width);
    endfunction

endpackage

// File: rtl/crc_unroll.sv
// rtl/crc_unroll.sv - combinational chain of keep-gated byte steps producing the next CRC register
module crc_unroll
    import crc_stream_pkg::*;
#(
    parameter int          CRC_W      = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter bit          REFLECT    = 1'b1,
    parameter int          DATA_BYTES = 4
) (
    input  logic [CRC_W-1:0]        crc_in,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [DATA_BYTES-1:0]   keep,
    output logic [CRC_W-1:0]        crc_out
);

    localparam logic [31:0] STEP_POLY = REFLECT ? reflect_poly(POLY, CRC_W)
                                                : (POLY & width_mask(CRC_W));

    logic [31:0] chain;

    always_comb begin
        chain = 32'(crc_in);
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (keep[i]) chain = crc_byte_step(chain, data[8*i +: 8], STEP_POLY, REFLECT, CRC_W);
        end
        crc_out = chain[CRC_W-1:0];
    end

endmodule

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC generator/checker, one result per frame
// CRC_STREAM_CHECK_EN adds the m_ok residue comparison port.
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int          CRC_W      = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT    = 1'b1,
    parameter int          DATA_BYTES = 4
`ifdef CRC_STREAM_CHECK_EN
    ,
    parameter logic [31:0] RESIDUE    = CRC32_RESIDUE
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CRC_W-1:0]        m_crc,
`ifdef CRC_STREAM_CHECK_EN
    output logic [15:0]             m_bytes,
    output logic                    m_ok
`else
    output logic [15:0]             m_bytes
`endif
);

    localparam logic [CRC_W-1:0] INIT_W   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_W = XOROUT[CRC_W-1:0];

    state_e            state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d, m_crc_q, m_crc_d;
    logic [15:0]       cnt_q, cnt_d, m_bytes_q, m_bytes_d;
    logic [CRC_W-1:0]  crc_base, crc_next;
    logic [15:0]       cnt_base, cnt_next;
    logic [16:0]       cnt_sum;
    logic [3:0]        keep_cnt;
    logic              accept;

    // A new frame always seeds from INIT, never from the previous frame's register.
    assign crc_base = (state_q == IDLE) ? INIT_W : crc_q;
    assign cnt_base = (state_q == IDLE) ? 16'd0 : cnt_q;
    assign s_ready  = (state_q != HOLD);
    assign m_valid  = (state_q == HOLD);
    assign accept   = s_valid && s_ready;
    assign m_crc    = m_crc_q;
    assign m_bytes  = m_bytes_q;

    crc_unroll #(
        .CRC_W      (CRC_W),
        .POLY       (POLY),
        .REFLECT    (REFLECT),
        .DATA_BYTES (DATA_BYTES)
    ) u_unroll (
        .crc_in  (crc_base),
        .data    (s_data),
        .keep    (s_keep),
        .crc_out (crc_next)
    );

    always_comb begin
        keep_cnt = 4'd0;
        for (int i = 0; i < DATA_BYTES; i++) keep_cnt = keep_cnt + {3'd0, s_keep[i]};
        cnt_sum  = {1'b0, cnt_base} + {13'd0, keep_cnt};
        cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

`ifdef CRC_STREAM_CHECK_EN
    logic m_ok_q, m_ok_d;
    assign m_ok = m_ok_q;
`endif

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        m_crc_d   = m_crc_q;
        m_bytes_d = m_bytes_q;
`ifdef CRC_STREAM_CHECK_EN
        m_ok_d    = m_ok_q;
`endif
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    crc_d = crc_next;
                    cnt_d = cnt_next;
                    if (s_last) begin
                        state_d   = HOLD;
                        m_crc_d   = crc_next ^ XOROUT_W;
                        m_bytes_d = cnt_next;
`ifdef CRC_STREAM_CHECK_EN
                        m_ok_d    = (crc_next == RESIDUE[CRC_W-1:0]);
`endif
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT_W;
            cnt_q     <= 16'd0;
            m_crc_q   <= '0;
            m_bytes_q <= 16'd0;
`ifdef CRC_STREAM_CHECK_EN
            m_ok_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            m_crc_q   <= m_crc_d;
            m_bytes_q <= m_bytes_d;
`ifdef CRC_STREAM_CHECK_EN
            m_ok_q    <= m_ok_d;
`endif
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - self-checking bench for crc_stream_engine (CRC-32 and CRC-16 instances)
`timescale 1ns/1ps
module tb_crc_stream_engine;

    typedef logic [7:0] bytes_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_ready, m_valid;
    logic [31:0] m_crc;
    logic [15:0] m_bytes;

    logic        s16_valid = 1'b0, s16_last = 1'b0, m16_ready = 1'b0;
    logic [7:0]  s16_data = '0;
    logic [0:0]  s16_keep = '0;
    logic        s16_ready, m16_valid;
    logic [15:0] m16_crc, m16_bytes;
`ifdef CRC_STREAM_CHECK_EN
    logic        m_ok, m16_ok;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crc_stream_engine u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_crc   (m_crc),
`ifdef CRC_STREAM_CHECK_EN
        .m_bytes (m_bytes),
        .m_ok    (m_ok)
`else
        .m_bytes (m_bytes)
`endif
    );

    crc_stream_engine #(
        .CRC_W      (16),
        .POLY       (32'h00001021),
        .INIT       (32'h0000FFFF),
        .XOROUT     (32'h00000000),
        .REFLECT    (1'b0),
        .DATA_BYTES (1)
    ) u_dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s16_valid),
        .s_ready (s16_ready),
        .s_data  (s16_data),
        .s_keep  (s16_keep),
        .s_last  (s16_last),
        .m_valid (m16_valid),
        .m_ready (m16_ready),
        .m_crc   (m16_crc),
`ifdef CRC_STREAM_CHECK_EN
        .m_bytes (m16_bytes),
        .m_ok    (m16_ok)
`else
        .m_bytes (m16_bytes)
`endif
    );

    // Standard reflected CRC-32 (poly 0xEDB88320 form); returns the register before the final XOR.
    function automatic logic [31:0] ref_crc32_raw(input bytes_t q);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (q[i]) begin
            r = r ^ {24'd0, q[i]};
            repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_crc16(input bytes_t q);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (q[i]) begin
            r = r ^ {q[i], 8'd0};
            repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL send_timeout s_ready=%b required=1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_result(input int delay, output logic [31:0] crc, output logic [15:0] nb,
                               output logic ok);
        int n;
        n = 0;
        while (m_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL result_timeout m_valid=%b required=1", m_valid);
        end
        crc = m_crc;
        nb  = m_bytes;
`ifdef CRC_STREAM_CHECK_EN
        ok  = m_ok;
`else
        ok  = 1'b0;
`endif
        repeat (delay) @(negedge clk);
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic send_vector1();
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b1);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready actual=%b required=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid actual=%b required=0", m_valid); end
        checks++; if (m_crc !== 32'h0) begin failures++; $display("FAIL rst_m_crc actual=%h required=0", m_crc); end
        checks++; if (m_bytes !== 16'h0) begin failures++; $display("FAIL rst_m_bytes actual=%h required=0", m_bytes); end
`ifdef CRC_STREAM_CHECK_EN
        checks++; if (m_ok !== 1'b0) begin failures++; $display("FAIL rst_m_ok actual=%b required=0", m_ok); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_vector();
        logic [31:0] crc; logic [15:0] nb; logic ok;
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL vec_early_valid actual=%b required=0", m_valid); end
        send_beat(32'h00000039, 4'h1, 1'b1);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL vec_latency actual=%b required=1", m_valid); end
        wait_result(0, crc, nb, ok);
        checks++; if (crc !== 32'hCBF43926) begin failures++; $display("FAIL vec_crc actual=%h required=cbf43926", crc); end
        checks++; if (nb !== 16'd9) begin failures++; $display("FAIL vec_bytes actual=%0d required=9", nb); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL vec_valid_drop actual=%b required=0", m_valid); end
        checks++; if (m_crc !== 32'hCBF43926) begin failures++; $display("FAIL vec_crc_kept actual=%h required=cbf43926", m_crc); end
    endtask

    task automatic test_empty();
        logic [31:0] crc; logic [15:0] nb; logic ok;
        send_beat($urandom, 4'h0, 1'b1);
        wait_result(0, crc, nb, ok);
        checks++; if (crc !== 32'h0) begin failures++; $display("FAIL empty_crc actual=%h required=0", crc); end
        checks++; if (nb !== 16'd0) begin failures++; $display("FAIL empty_bytes actual=%0d required=0", nb); end
    endtask

    task automatic test_backpressure();
        logic [31:0] crc; logic [15:0] nb; logic ok;
        send_vector1();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = $urandom; s_keep = 4'hF; s_last = 1'b1;
            checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready cyc=%0d actual=%b required=0", i, s_ready); end
            checks++; if (m_crc !== 32'hCBF43926) begin failures++; $display("FAIL bp_crc_stable cyc=%0d actual=%h required=cbf43926", i, m_crc); end
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_no_bypass actual=%b required=0", s_ready); end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop actual=%b required=0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back actual=%b required=1", s_ready); end
        send_vector1();
        wait_result(0, crc, nb, ok);
        checks++; if (crc !== 32'hCBF43926) begin failures++; $display("FAIL bp_repeat_crc actual=%h required=cbf43926", crc); end
        checks++; if (nb !== 16'd9) begin failures++; $display("FAIL bp_repeat_bytes actual=%0d required=9", nb); end
    endtask

    task automatic test_crc16();
        bytes_t q;
        int n;
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s16_valid = 1'b1; s16_data = q[i]; s16_keep = 1'b1; s16_last = (i == 8);
            @(posedge clk);
            #1;
        end
        s16_valid = 1'b0;
        n = 0;
        while (m16_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (m16_valid !== 1'b1) begin failures++; $display("FAIL c16_valid actual=%b required=1", m16_valid); end
        checks++; if (m16_crc !== 16'h29B1) begin failures++; $display("FAIL c16_crc actual=%h required=29b1", m16_crc); end
        checks++; if (m16_crc !== ref_crc16(q)) begin failures++; $display("FAIL c16_model actual=%h required=%h", m16_crc, ref_crc16(q)); end
        checks++; if (m16_bytes !== 16'd9) begin failures++; $display("FAIL c16_bytes actual=%0d required=9", m16_bytes); end
        @(negedge clk); m16_ready = 1'b1;
        @(posedge clk); #1; m16_ready = 1'b0;
    endtask

`ifdef CRC_STREAM_CHECK_EN
    task automatic test_check();
        logic [31:0] crc; logic [15:0] nb; logic ok;
        for (int pass = 0; pass < 2; pass++) begin
            send_beat(32'h34333231, 4'hF, 1'b0);
            send_beat(pass == 0 ? 32'h38373635 : 32'h38373634, 4'hF, 1'b0);
            send_beat(32'hF4392639, 4'hF, 1'b0);
            send_beat(32'h000000CB, 4'h1, 1'b1);
            wait_result(0, crc, nb, ok);
            checks++; if (ok !== (pass == 0)) begin failures++; $display("FAIL check_ok pass=%0d actual=%b required=%b", pass, ok, pass == 0); end
            checks++; if (nb !== 16'd13) begin failures++; $display("FAIL check_bytes actual=%0d required=13", nb); end
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] crc, w, raw; logic [15:0] nb; logic ok;
        logic [3:0] k;
        int nbeats;
        for (int f = 0; f < 30; f++) begin
            bytes_t q;
            nbeats = $urandom_range(1, 5);
            for (int b = 0; b < nbeats; b++) begin
                w = $urandom;
                k = 4'($urandom);
                for (int i = 0; i < 4; i++) if (k[i]) q.push_back(w[8*i +: 8]);
                send_beat(w, k, b == nbeats - 1);
            end
            raw = ref_crc32_raw(q);
            wait_result($urandom_range(0, 3), crc, nb, ok);
            checks++; if (crc !== ~raw) begin failures++; $display("FAIL rand_crc frame=%0d actual=%h required=%h", f, crc, ~raw); end
            checks++; if (nb !== 16'(q.size())) begin failures++; $display("FAIL rand_bytes frame=%0d actual=%0d required=%0d", f, nb, q.size()); end
`ifdef CRC_STREAM_CHECK_EN
            checks++; if (ok !== (raw == 32'hDEBB20E3)) begin failures++; $display("FAIL rand_ok frame=%0d actual=%b required=%b", f, ok, raw == 32'hDEBB20E3); end
`endif
        end
    endtask

    task automatic test_saturation();
        logic [31:0] crc, w, raw; logic [15:0] nb; logic ok;
        bytes_t q;
        w = $urandom;
        for (int b = 0; b < 16400; b++) begin
            for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
            send_beat(w, 4'hF, b == 16399);
        end
        raw = ref_crc32_raw(q);
        wait_result(0, crc, nb, ok);
        checks++; if (nb !== 16'hFFFF) begin failures++; $display("FAIL sat_bytes actual=%h required=ffff", nb); end
        checks++; if (crc !== ~raw) begin failures++; $display("FAIL sat_crc actual=%h required=%h", crc, ~raw); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] crc; logic [15:0] nb; logic ok;
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL mrst_s_ready actual=%b required=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mrst_m_valid actual=%b required=0", m_valid); end
        checks++; if (m_crc !== 32'h0) begin failures++; $display("FAIL mrst_m_crc actual=%h required=0", m_crc); end
        checks++; if (m_bytes !== 16'h0) begin failures++; $display("FAIL mrst_m_bytes actual=%h required=0", m_bytes); end
        @(negedge clk);
        rst_n = 1'b1;
        send_vector1();
        wait_result(0, crc, nb, ok);
        checks++; if (crc !== 32'hCBF43926) begin failures++; $display("FAIL mrst_crc actual=%h required=cbf43926", crc); end
        checks++; if (nb !== 16'd9) begin failures++; $display("FAIL mrst_bytes actual=%0d required=9", nb); end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_empty();
        test_backpressure();
        test_crc16();
`ifdef CRC_STREAM_CHECK_EN
        test_check();
`endif
        test_random();
        test_saturation();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
